intra16_recon_decode: RTL and testbench

- Decoder-side counterpart of the luma 16x16 intra mode picker.
- Consumes the picker's outputs and rebuilds the 16x16 reconstructed luma block, as the decoder or the bitstream-side reconstruction loop will see it:
  - chosen mode (mode_i16[1:0]);
  - quantized DC levels;
  - quantized AC levels.
- Flow: predictor generation, DC dequantization, inverse WHT, per-4x4 dequant + inverse DCT, add prediction, clip.
- Sits after the mode-decision stage and feeds the neighbour-edge buffers and the output frame writer.

---
 rtl/intra16_recon_decode_if.sv | 33 +++
 rtl/intra16_recon_decode.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_intra16_recon_decode.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/intra16_recon_decode_if.sv
// Bundle of the request/response signals of the 16x16 luma reconstruction block.
`timescale 1ns/1ps
interface intra16_recon_decode_if;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned EDGE_W = 16 * PIX_W;
  localparam int unsigned LEV_W  = 16;
  localparam int unsigned OUT_W  = 256 * PIX_W;

  logic                  start;
  logic [9:0]            x;
  logic [9:0]            y;
  logic [1:0]            mode;
  logic [PIX_W-1:0]      top_left;
  logic [EDGE_W-1:0]     top;
  logic [EDGE_W-1:0]     left;
  logic [16*LEV_W-1:0]   dc_levels;
  logic [256*LEV_W-1:0]  ac_levels;
  logic [16*LEV_W-1:0]   q_dc;
  logic [16*LEV_W-1:0]   q_ac;
  logic [OUT_W-1:0]      out;
  logic                  busy;
  logic                  done;

  modport master (
    output start, x, y, mode, top_left, top, left, dc_levels, ac_levels, q_dc, q_ac,
    input  out, busy, done
  );

  modport slave (
    input  start, x, y, mode, top_left, top, left, dc_levels, ac_levels, q_dc, q_ac,
    output out, busy, done
  );
endinterface

// File: rtl/intra16_recon_decode.sv
// Rebuilds the 16x16 reconstructed luma block from the picked intra mode and
// its quantized Y2/Y1 levels: predictor, Y2 dequant, inverse WHT, per-4x4
// dequant + inverse DCT, add prediction and clip. One 4x4 block per cycle.
`timescale 1ns/1ps
module intra16_recon_decode #(
  parameter int unsigned BLOCK_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  intra16_recon_decode_if.slave bus
);
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned NPIX   = BLOCK_SIZE * BLOCK_SIZE;
  localparam int unsigned LEV_W  = 16;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned NCOEF  = 16;
  localparam int unsigned EDGE_W = BLOCK_SIZE * PIX_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WHT_V, S_WHT_H, S_IDCT, S_DONE
  } state_t;

  state_t state, state_next;
  logic   accept_c;

  logic [1:0]               cur_mode;
  logic                     has_left;
  logic                     has_top;
  logic [PIX_W-1:0]         cur_top_left;
  logic [EDGE_W-1:0]        cur_top;
  logic [EDGE_W-1:0]        cur_left;
  logic [NCOEF*LEV_W-1:0]   cur_dc_levels;
  logic [NCOEF*LEV_W-1:0]   cur_q_dc;
  logic [NCOEF*LEV_W-1:0]   cur_q_ac;
  logic [256*LEV_W-1:0]     cur_ac;

  logic [NPIX*PIX_W-1:0]    pred, pred_c, pix;
  logic signed [ACC_W-1:0]  y2      [NCOEF];
  logic signed [ACC_W-1:0]  y2_c    [NCOEF];
  logic signed [ACC_W-1:0]  wht_tmp [NCOEF];
  logic signed [ACC_W-1:0]  wht_tmp_c [NCOEF];
  logic signed [ACC_W-1:0]  dc_coef [NCOEF];
  logic signed [ACC_W-1:0]  dc_coef_c [NCOEF];
  logic [3:0]               blk;
  logic [16*PIX_W-1:0]      recon_c;
  logic                     busy_reg, done_reg;

  // Saturate a transform-domain value to an 8-bit pixel.
  function automatic logic [PIX_W-1:0] clip_pix(input logic signed [ACC_W-1:0] v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return v[PIX_W-1:0];
  endfunction

  // (a * (20091 + 65536)) >> 16
  function automatic logic signed [ACC_W-1:0] mul1(input logic signed [ACC_W-1:0] a);
    logic signed [63:0] p;
    p = 64'(a) * 64'sd85627;
    return 32'(p >>> 16);
  endfunction

  // (a * 35468) >> 16
  function automatic logic signed [ACC_W-1:0] mul2(input logic signed [ACC_W-1:0] a);
    logic signed [63:0] p;
    p = 64'(a) * 64'sd35468;
    return 32'(p >>> 16);
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; start only honoured in IDLE.
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_next = S_LOAD;
          accept_c   = 1'b1;
        end
      end
      S_LOAD:  state_next = S_WHT_V;
      S_WHT_V: state_next = S_WHT_H;
      S_WHT_H: state_next = S_IDCT;
      S_IDCT:  if (blk == 4'd15) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  logic [11:0]        sum_top_c, sum_left_c;
  logic [PIX_W-1:0]   dc_pred_c;
  logic signed [10:0] tm_c;

  // Predictor generation from the latched neighbours.
  always_comb begin
    sum_top_c  = '0;
    sum_left_c = '0;
    dc_pred_c  = 8'd128;
    tm_c       = '0;
    pred_c     = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      sum_top_c  = sum_top_c  + 12'(cur_top[PIX_W*i +: PIX_W]);
      sum_left_c = sum_left_c + 12'(cur_left[PIX_W*i +: PIX_W]);
    end
    unique case ({has_left, has_top})
      2'b11:   dc_pred_c = 8'((13'(sum_top_c) + 13'(sum_left_c) + 13'd16) >> 5);
      2'b01:   dc_pred_c = 8'((sum_top_c + 12'd8) >> 4);
      2'b10:   dc_pred_c = 8'((sum_left_c + 12'd8) >> 4);
      default: dc_pred_c = 8'd128;
    endcase
    for (int r = 0; r < BLOCK_SIZE; r++) begin
      for (int c = 0; c < BLOCK_SIZE; c++) begin
        tm_c = $signed({3'b000, cur_top[PIX_W*c +: PIX_W]})
             + $signed({3'b000, cur_left[PIX_W*r +: PIX_W]})
             - $signed({3'b000, cur_top_left});
        unique case (cur_mode)
          2'd0: pred_c[PIX_W*(BLOCK_SIZE*r + c) +: PIX_W] = dc_pred_c;
          2'd1: pred_c[PIX_W*(BLOCK_SIZE*r + c) +: PIX_W] = clip_pix(ACC_W'(tm_c));
          2'd2: pred_c[PIX_W*(BLOCK_SIZE*r + c) +: PIX_W] = cur_top[PIX_W*c +: PIX_W];
          default: pred_c[PIX_W*(BLOCK_SIZE*r + c) +: PIX_W] = cur_left[PIX_W*r +: PIX_W];
        endcase
      end
    end
  end

  // Y2 dequantization: signed level times unsigned factor, 32-bit wrap.
  always_comb begin
    for (int k = 0; k < NCOEF; k++) begin
      y2_c[k] = ACC_W'($signed(cur_dc_levels[LEV_W*k +: LEV_W]))
              * $signed({16'b0, cur_q_dc[LEV_W*k +: LEV_W]});
    end
  end

  logic signed [ACC_W-1:0] va0, va1, va2, va3;

  // Inverse WHT, vertical butterflies per column.
  always_comb begin
    va0 = '0; va1 = '0; va2 = '0; va3 = '0;
    for (int k = 0; k < NCOEF; k++) wht_tmp_c[k] = '0;
    for (int i = 0; i < 4; i++) begin
      va0 = y2[i] + y2[12+i];
      va1 = y2[4+i] + y2[8+i];
      va2 = y2[4+i] - y2[8+i];
      va3 = y2[i] - y2[12+i];
      wht_tmp_c[i]    = va0 + va1;
      wht_tmp_c[8+i]  = va0 - va1;
      wht_tmp_c[4+i]  = va3 + va2;
      wht_tmp_c[12+i] = va3 - va2;
    end
  end

  logic signed [ACC_W-1:0] hdc, ha0, ha1, ha2, ha3;

  // Inverse WHT, horizontal butterflies per row with +3 rounding; result k is block k's DC.
  always_comb begin
    hdc = '0; ha0 = '0; ha1 = '0; ha2 = '0; ha3 = '0;
    for (int k = 0; k < NCOEF; k++) dc_coef_c[k] = '0;
    for (int i = 0; i < 4; i++) begin
      hdc = wht_tmp[4*i] + 32'sd3;
      ha0 = hdc + wht_tmp[4*i+3];
      ha1 = wht_tmp[4*i+1] + wht_tmp[4*i+2];
      ha2 = wht_tmp[4*i+1] - wht_tmp[4*i+2];
      ha3 = hdc - wht_tmp[4*i+3];
      dc_coef_c[4*i]   = (ha0 + ha1) >>> 3;
      dc_coef_c[4*i+1] = (ha3 + ha2) >>> 3;
      dc_coef_c[4*i+2] = (ha0 - ha1) >>> 3;
      dc_coef_c[4*i+3] = (ha3 - ha2) >>> 3;
    end
  end

  logic [16*LEV_W-1:0]     blk_lev_c;
  logic signed [ACC_W-1:0] coef_c [NCOEF];
  logic signed [ACC_W-1:0] vt_c   [NCOEF];
  logic signed [ACC_W-1:0] rv_c   [NCOEF];
  logic signed [ACC_W-1:0] ta, tb, tc, td, tdc, pv;

  // Current block: dequant, inverse DCT, add prediction, clip.
  always_comb begin
    ta = '0; tb = '0; tc = '0; td = '0; tdc = '0; pv = '0;
    recon_c   = '0;
    blk_lev_c = cur_ac[{blk, 8'h00} +: 16*LEV_W];
    coef_c[0] = dc_coef[blk];
    for (int j = 1; j < NCOEF; j++) begin
      coef_c[j] = ACC_W'($signed(blk_lev_c[LEV_W*j +: LEV_W]))
                * $signed({16'b0, cur_q_ac[LEV_W*j +: LEV_W]});
    end
    for (int k = 0; k < NCOEF; k++) begin
      vt_c[k] = '0;
      rv_c[k] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      ta = coef_c[i] + coef_c[8+i];
      tb = coef_c[i] - coef_c[8+i];
      tc = mul2(coef_c[4+i]) - mul1(coef_c[12+i]);
      td = mul1(coef_c[4+i]) + mul2(coef_c[12+i]);
      vt_c[4*i]   = ta + td;
      vt_c[4*i+1] = tb + tc;
      vt_c[4*i+2] = tb - tc;
      vt_c[4*i+3] = ta - td;
    end
    for (int i = 0; i < 4; i++) begin
      tdc = vt_c[i] + 32'sd4;
      ta  = tdc + vt_c[8+i];
      tb  = tdc - vt_c[8+i];
      tc  = mul2(vt_c[4+i]) - mul1(vt_c[12+i]);
      td  = mul1(vt_c[4+i]) + mul2(vt_c[12+i]);
      rv_c[4*i]   = ta + td;
      rv_c[4*i+1] = tb + tc;
      rv_c[4*i+2] = tb - tc;
      rv_c[4*i+3] = ta - td;
    end
    for (int i = 0; i < 4; i++) begin
      for (int x = 0; x < 4; x++) begin
        pv = $signed({24'b0, pred[{blk[3:2], 2'(i), blk[1:0], 2'(x), 3'b000} +: PIX_W]})
           + (rv_c[4*i+x] >>> 3);
        recon_c[PIX_W*(4*i+x) +: PIX_W] = clip_pix(pv);
      end
    end
  end

  // Datapath registers, block counter, output pixels and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_mode      <= '0;
      has_left      <= 1'b0;
      has_top       <= 1'b0;
      cur_top_left  <= '0;
      cur_top       <= '0;
      cur_left      <= '0;
      cur_dc_levels <= '0;
      cur_q_dc      <= '0;
      cur_q_ac      <= '0;
      cur_ac        <= '0;
      pred          <= '0;
      pix           <= '0;
      blk           <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      for (int k = 0; k < NCOEF; k++) begin
        y2[k]      <= '0;
        wht_tmp[k] <= '0;
        dc_coef[k] <= '0;
      end
    end else begin
      if (accept_c) begin
        cur_mode      <= bus.mode;
        has_left      <= (bus.x != 10'd0);
        has_top       <= (bus.y != 10'd0);
        cur_top_left  <= bus.top_left;
        cur_top       <= bus.top;
        cur_left      <= bus.left;
        cur_dc_levels <= bus.dc_levels;
        cur_q_dc      <= bus.q_dc;
        cur_q_ac      <= bus.q_ac;
        cur_ac        <= bus.ac_levels;
      end
      if (state == S_LOAD) begin
        pred <= pred_c;
        for (int k = 0; k < NCOEF; k++) y2[k] <= y2_c[k];
      end
      if (state == S_WHT_V) begin
        for (int k = 0; k < NCOEF; k++) wht_tmp[k] <= wht_tmp_c[k];
      end
      if (state == S_WHT_H) begin
        for (int k = 0; k < NCOEF; k++) dc_coef[k] <= dc_coef_c[k];
        blk <= '0;
      end
      if (state == S_IDCT) begin
        blk <= blk + 4'd1;
        for (int i = 0; i < 4; i++) begin
          for (int x = 0; x < 4; x++) begin
            pix[{blk[3:2], 2'(i), blk[1:0], 2'(x), 3'b000} +: PIX_W] <= recon_c[PIX_W*(4*i+x) +: PIX_W];
          end
        end
      end
      busy_reg <= (state_next == S_LOAD) || (state_next == S_WHT_V) ||
                  (state_next == S_WHT_H) || (state_next == S_IDCT);
      done_reg <= (state_next == S_DONE);
    end
  end

  assign bus.out  = pix;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
endmodule

// File: tb/tb_intra16_recon_decode.sv
// Randomized scoreboard bench for intra16_recon_decode with a matrix-level reference model.
`timescale 1ns/1ps
module tb_intra16_recon_decode;
  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;

  intra16_recon_decode_if bus();

  intra16_recon_decode #(.BLOCK_SIZE(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2047:0] pix;
    int            due;
  } exp_t;

  exp_t sb[$];
  logic [2047:0] last_exp;

  logic [9:0]    s_x, s_y;
  logic [1:0]    s_mode;
  logic [7:0]    s_tl;
  logic [127:0]  s_top, s_left;
  logic [255:0]  s_dcl, s_qdc, s_qac;
  logic [4095:0] s_acl;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  function automatic int clip(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic int m1(input int a);
    longint p;
    p = longint'(a) * 85627;
    return int'(p >>> 16);
  endfunction

  function automatic int m2(input int a);
    longint p;
    p = longint'(a) * 35468;
    return int'(p >>> 16);
  endfunction

  // One-dimensional 4-point inverse DCT.
  function automatic void idct1(input int i0, i1, i2, i3, output int o0, o1, o2, o3);
    int a, b, c, d;
    a = i0 + i2;
    b = i0 - i2;
    c = m2(i1) - m1(i3);
    d = m1(i1) + m2(i3);
    o0 = a + d; o1 = b + c; o2 = b - c; o3 = a - d;
  endfunction

  // Reference reconstruction of the current stimulus.
  function automatic logic [2047:0] ref_model();
    int tp[16], lp[16], pr[16][16], co[16], w[16];
    int xm[4][4], ym[4][4], cm[4][4], vm[4][4], rm[4][4];
    int hm[4][4];
    int st, sl, dcv, acc;
    logic [2047:0] res;
    hm = '{'{1, 1, 1, 1}, '{1, 1, -1, -1}, '{1, -1, -1, 1}, '{1, -1, 1, -1}};
    st = 0; sl = 0;
    for (int i = 0; i < 16; i++) begin
      tp[i] = int'(s_top[8*i +: 8]);
      lp[i] = int'(s_left[8*i +: 8]);
      st += tp[i];
      sl += lp[i];
    end
    if (s_x != 0 && s_y != 0) dcv = (st + sl + 16) >> 5;
    else if (s_y != 0)        dcv = (st + 8) >> 4;
    else if (s_x != 0)        dcv = (sl + 8) >> 4;
    else                      dcv = 128;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        case (s_mode)
          2'd0: pr[r][c] = dcv;
          2'd1: pr[r][c] = clip(tp[c] + lp[r] - int'(s_tl));
          2'd2: pr[r][c] = tp[c];
          default: pr[r][c] = lp[r];
        endcase
    for (int k = 0; k < 16; k++)
      co[k] = int'($signed(s_dcl[16*k +: 16])) * int'(s_qdc[16*k +: 16]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) xm[r][c] = co[4*r + c];
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 4; c++) begin
        acc = 0;
        for (int r = 0; r < 4; r++) acc += hm[k][r] * xm[r][c];
        ym[k][c] = acc;
      end
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        acc = 0;
        for (int c = 0; c < 4; c++) acc += hm[k][c] * ym[r][c];
        w[4*r + k] = (acc + 3) >>> 3;
      end
    res = '0;
    for (int b = 0; b < 16; b++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          cm[r][c] = (r == 0 && c == 0) ? w[b]
                   : int'($signed(s_acl[16*(16*b + 4*r + c) +: 16])) * int'(s_qac[16*(4*r + c) +: 16]);
      for (int c = 0; c < 4; c++)
        idct1(cm[0][c], cm[1][c], cm[2][c], cm[3][c], vm[0][c], vm[1][c], vm[2][c], vm[3][c]);
      for (int r = 0; r < 4; r++)
        idct1(vm[r][0], vm[r][1], vm[r][2], vm[r][3], rm[r][0], rm[r][1], rm[r][2], rm[r][3]);
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          res[8*(16*(4*(b/4) + r) + 4*(b%4) + c) +: 8] =
            8'(clip(pr[4*(b/4) + r][4*(b%4) + c] + ((rm[r][c] + 4) >>> 3)));
    end
    return res;
  endfunction

  task automatic clear_stim();
    s_x = '0; s_y = '0; s_mode = '0; s_tl = '0; s_top = '0; s_left = '0;
    s_dcl = '0; s_qdc = '0; s_qac = '0; s_acl = '0;
  endtask

  task automatic random_stim();
    s_x    = ($urandom_range(0, 1) != 0) ? 10'($urandom_range(1, 1023)) : 10'd0;
    s_y    = ($urandom_range(0, 1) != 0) ? 10'($urandom_range(1, 1023)) : 10'd0;
    s_mode = 2'($urandom_range(0, 3));
    s_tl   = 8'($urandom_range(0, 255));
    for (int i = 0; i < 16; i++) begin
      s_top[8*i +: 8]   = 8'($urandom_range(0, 255));
      s_left[8*i +: 8]  = 8'($urandom_range(0, 255));
      s_dcl[16*i +: 16] = 16'(int'($urandom_range(0, 60)) - 30);
      s_qdc[16*i +: 16] = 16'($urandom_range(1, 200));
      s_qac[16*i +: 16] = 16'($urandom_range(1, 60));
    end
    for (int j = 0; j < 256; j++)
      s_acl[16*j +: 16] = ($urandom_range(0, 2) == 0) ? 16'(int'($urandom_range(0, 40)) - 20) : 16'd0;
  endtask

  // Push the expected result, then pulse start for one cycle (called on a negedge).
  task automatic issue();
    exp_t e;
    e.pix = ref_model();
    e.due = cyc + 20;
    last_exp = e.pix;
    sb.push_back(e);
    bus.x = s_x; bus.y = s_y; bus.mode = s_mode; bus.top_left = s_tl;
    bus.top = s_top; bus.left = s_left; bus.dc_levels = s_dcl; bus.ac_levels = s_acl;
    bus.q_dc = s_qdc; bus.q_ac = s_qac;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_start: busy=%b required 1", bus.busy);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.done !== 1'b1) begin
      bad++;
      $display("FAIL done_timeout: done not seen within %0d cycles", n);
    end
    @(negedge clk);
  endtask

  task automatic run();
    issue();
    wait_done();
  endtask

  task automatic check_const(input string name, input logic [7:0] v);
    logic [2047:0] e;
    e = {256{v}};
    total++;
    if (bus.out !== e) begin
      bad++;
      $display("FAIL %s: out pixel0=%0d pixel255=%0d required all %0d",
               name, bus.out[7:0], bus.out[2047:2040], v);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  initial begin : monitor
    exp_t e;
    int   first;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: done at cycle %0d with nothing pending", cyc);
        end else begin
          e = sb.pop_front();
          total++;
          if (bus.out !== e.pix) begin
            bad++;
            first = 0;
            for (int p = 0; p < 256; p++)
              if (bus.out[8*p +: 8] !== e.pix[8*p +: 8]) begin
                first = p;
                break;
              end
            $display("FAIL out_pixels: pixel(%0d,%0d)=%0d required %0d", first / 16, first % 16,
                     bus.out[8*first +: 8], e.pix[8*first +: 8]);
          end
          total++;
          if (cyc != e.due) begin
            bad++;
            $display("FAIL done_latency: done at cycle %0d required %0d", cyc, e.due);
          end
          total++;
          if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_at_done: busy=%b required 0", bus.busy);
          end
        end
      end
    end
  end

  initial begin : driver
    int dcount;
    total = 0; bad = 0; cyc = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.x = '0; bus.y = '0; bus.mode = '0; bus.top_left = '0;
    bus.top = '0; bus.left = '0; bus.dc_levels = '0; bus.ac_levels = '0;
    bus.q_dc = '0; bus.q_ac = '0;
    repeat (3) @(negedge clk);
    total++; if (bus.out !== '0)   begin bad++; $display("FAIL reset_out: out nonzero, pixel0=%0d required 0", bus.out[7:0]); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: busy=%b required 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: done=%b required 0", bus.done); end
    rst = 1'b0;
    @(negedge clk);

    // Vertical prediction with zero residual.
    clear_stim();
    s_mode = 2'd2; s_x = 10'd3; s_y = 10'd2;
    for (int i = 0; i < 16; i++) s_top[8*i +: 8] = 8'(10 * i);
    run();

    // DC prediction with no neighbours.
    clear_stim();
    run();
    check_const("dc_no_neighbours", 8'd128);

    // Single Y2 level through WHT and IDCT.
    clear_stim();
    s_dcl[15:0] = 16'd1; s_qdc[15:0] = 16'd64;
    run();
    check_const("dc_plus_one", 8'd129);

    // Horizontal prediction saturating high and low.
    s_mode = 2'd3; s_left = {16{8'd255}};
    run();
    check_const("clip_high", 8'd255);
    s_left = '0; s_dcl[15:0] = 16'hFFFF;
    run();
    check_const("clip_low", 8'd0);

    // TrueMotion with negative and positive results.
    clear_stim();
    s_mode = 2'd1; s_tl = 8'd100; s_top = {16{8'd50}}; s_left = {16{8'd30}};
    run();
    check_const("tm_negative", 8'd0);
    s_tl = 8'd20;
    run();
    check_const("tm_sixty", 8'd60);

    // Start during IDCT must be ignored.
    random_stim();
    s_mode = 2'd2;
    issue();
    repeat (7) @(negedge clk);
    bus.mode = 2'd3;
    bus.top  = ~s_top;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    total++;
    if (bus.out !== last_exp) begin
      bad++;
      $display("FAIL out_hold: out changed after done, pixel0=%0d required %0d", bus.out[7:0], last_exp[7:0]);
    end

    // Randomized transactions.
    for (int t = 0; t < 25; t++) begin
      random_stim();
      run();
    end

    // Reset in the middle of IDCT.
    random_stim();
    issue();
    repeat (9) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    total++; if (bus.out !== '0)    begin bad++; $display("FAIL abort_out: pixel0=%0d required 0", bus.out[7:0]); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy: busy=%b required 0", bus.busy); end
    rst = 1'b0;
    dcount = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done === 1'b1) dcount++;
    end
    total++;
    if (dcount != 0) begin
      bad++;
      $display("FAIL abort_no_done: %0d done pulses required 0", dcount);
    end

    // Recovery after abort.
    random_stim();
    run();

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d results pending required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
